// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared definitions for the instruction sequencer: opcode
//            constants, ALU-select constants, FSM state encoding, the decode
//            word and a branch-condition helper.
// Config   : SINGLE_STEP_EN adds the WAIT state to the state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Opcodes (7-bit field ir[IW-1:8])
  localparam logic [6:0] c_op_nop  = 7'h00;
  localparam logic [6:0] c_op_mova = 7'h01;  // regA := literal
  localparam logic [6:0] c_op_movb = 7'h02;  // regB := literal
  localparam logic [6:0] c_op_add  = 7'h10;  // regA := regA + regB, flags
  localparam logic [6:0] c_op_sub  = 7'h11;  // regA := regA - regB, flags
  localparam logic [6:0] c_op_and  = 7'h12;  // regA := regA & regB, flags
  localparam logic [6:0] c_op_or   = 7'h13;  // regA := regA | regB, flags
  localparam logic [6:0] c_op_cmp  = 7'h14;  // flags from regA - regB only
  localparam logic [6:0] c_op_jmp  = 7'h40;
  localparam logic [6:0] c_op_jeq  = 7'h41;
  localparam logic [6:0] c_op_jne  = 7'h42;
  localparam logic [6:0] c_op_jlt  = 7'h43;
  localparam logic [6:0] c_op_jcr  = 7'h44;
  localparam logic [6:0] c_op_halt = 7'h7F;

  // ALU operand mux selects
  localparam logic [1:0] c_sel_rega = 2'd0;
  localparam logic [1:0] c_sel_regb = 2'd1;
  localparam logic [1:0] c_sel_lit  = 2'd2;
  localparam logic [1:0] c_sel_zero = 2'd3;

  // ALU operations
  localparam logic [2:0] c_alu_pass = 3'd0;
  localparam logic [2:0] c_alu_add  = 3'd1;
  localparam logic [2:0] c_alu_sub  = 3'd2;
  localparam logic [2:0] c_alu_and  = 3'd3;
  localparam logic [2:0] c_alu_or   = 3'd4;

  // FSM state encodings
  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_halt   = 3'd3;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] c_st_wait   = 3'd4;
`endif

  typedef enum logic [2:0] {
`ifdef SINGLE_STEP_EN
    ST_WAIT   = c_st_wait,
`endif
    ST_FETCH  = c_st_fetch,
    ST_DECODE = c_st_decode,
    ST_EXEC   = c_st_exec,
    ST_HALT   = c_st_halt
  } state_e;

  typedef struct packed {
    logic       la;
    logic       lb;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu_op;
    logic       flag_we;
    logic       is_branch;
    logic       is_halt;
  } dec_t;

  // Branch condition against the flags held from earlier instructions.
  function automatic logic branch_taken(input logic [6:0] op,
                                        input logic z, input logic n,
                                        input logic c);
    case (op)
      c_op_jmp: branch_taken = 1'b1;
      c_op_jeq: branch_taken = z;
      c_op_jne: branch_taken = ~z;
      c_op_jlt: branch_taken = n;
      c_op_jcr: branch_taken = c;
      default:  branch_taken = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Purely combinational map from a 7-bit opcode to the decode word.
//            Any opcode not listed decodes to the all-zero word, which makes
//            it behave exactly like NOP.
// Ports    : opcode_i [6:0]  opcode field of the instruction register
//            dec_o           decode word (load enables, mux selects, ALU op,
//                            flag write, branch and halt markers)
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import seq_pkg::*;
(
  input  logic [6:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      c_op_mova: begin
        dec_o.la     = 1'b1;
        dec_o.sa     = c_sel_lit;
        dec_o.sb     = c_sel_zero;
        dec_o.alu_op = c_alu_pass;
      end
      c_op_movb: begin
        dec_o.lb     = 1'b1;
        dec_o.sa     = c_sel_lit;
        dec_o.sb     = c_sel_zero;
        dec_o.alu_op = c_alu_pass;
      end
      c_op_add, c_op_sub, c_op_and, c_op_or: begin
        dec_o.la      = 1'b1;
        dec_o.sa      = c_sel_rega;
        dec_o.sb      = c_sel_regb;
        dec_o.flag_we = 1'b1;
        case (opcode_i)
          c_op_add: dec_o.alu_op = c_alu_add;
          c_op_sub: dec_o.alu_op = c_alu_sub;
          c_op_and: dec_o.alu_op = c_alu_and;
          default:  dec_o.alu_op = c_alu_or;
        endcase
      end
      c_op_cmp: begin
        dec_o.sa      = c_sel_rega;
        dec_o.sb      = c_sel_regb;
        dec_o.alu_op  = c_alu_sub;
        dec_o.flag_we = 1'b1;
      end
      c_op_jmp, c_op_jeq, c_op_jne, c_op_jlt, c_op_jcr: begin
        dec_o.is_branch = 1'b1;
      end
      c_op_halt: begin
        dec_o.is_halt = 1'b1;
      end
      default: dec_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Three-cycle FETCH/DECODE/EXEC instruction sequencer with PC,
//            Z/N/C flag register, HALT state and a saturating retired count.
// Config   : SINGLE_STEP_EN - adds input step and a WAIT state after EXEC;
//            the sequencer only proceeds to FETCH on a cycle with step=1.
// Ports    : clk, rst         clock, synchronous active-high reset
//            step             (SINGLE_STEP_EN only) advance from WAIT
//            im_data [IW]     instruction at pc_out (combinational read)
//            alu_z/n/c        ALU status for the current EXEC operands
//            pc_out [PC_W]    instruction-memory address
//            la, lb           regA / regB load enables (EXEC only)
//            sa, sb [2]       ALU A/B mux selects (EXEC only)
//            alu_op [3]       ALU operation (EXEC only)
//            literal [8]      literal field of the latched instruction
//            halted           high while in HALT
//            retired [16]     executed-instruction count, saturating
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 15
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [IW-1:0]   im_data,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_c,
  output logic [PC_W-1:0] pc_out,
  output logic            la,
  output logic            lb,
  output logic [1:0]      sa,
  output logic [1:0]      sb,
  output logic [2:0]      alu_op,
  output logic [7:0]      literal,
  output logic            halted,
  output logic [15:0]     retired
);

  state_e          state_q,   state_d;
  logic [PC_W-1:0] pc_q,      pc_d;
  logic [IW-1:0]   ir_q,      ir_d;
  logic            z_q,       z_d;
  logic            n_q,       n_d;
  logic            c_q,       c_d;
  logic [15:0]     retired_q, retired_d;

  logic [6:0] w_opcode;
  dec_t       w_dec;
  logic       w_exec;

  assign w_opcode = ir_q[IW-1:8];
  assign w_exec   = (state_q == ST_EXEC);

  instr_decoder u_decoder (
    .opcode_i (w_opcode),
    .dec_o    (w_dec)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = im_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_dec.flag_we) begin
          z_d = alu_z;
          n_d = alu_n;
          c_d = alu_c;
        end
        if (retired_q != 16'hFFFF) begin
          retired_d = retired_q + 16'd1;
        end
        if (w_dec.is_halt) begin
          state_d = ST_HALT;  // PC frozen on the halt instruction
        end else begin
          // Branch test uses z_q/n_q/c_q: flags from before this EXEC.
          if (w_dec.is_branch && branch_taken(w_opcode, z_q, n_q, c_q)) begin
            pc_d = PC_W'(ir_q[7:0]);
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
`ifdef SINGLE_STEP_EN
          state_d = ST_WAIT;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`ifdef SINGLE_STEP_EN
      ST_WAIT: begin
        if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      retired_q <= retired_d;
    end
  end

  // Datapath controls are gated to EXEC so DECODE and HALT never load.
  assign la      = w_exec & w_dec.la;
  assign lb      = w_exec & w_dec.lb;
  assign sa      = w_exec ? w_dec.sa     : 2'b00;
  assign sb      = w_exec ? w_dec.sb     : 2'b00;
  assign alu_op  = w_exec ? w_dec.alu_op : 3'b000;
  assign pc_out  = pc_q;
  assign literal = ir_q[7:0];
  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed self-checking bench for instr_sequencer. A small
//            instruction memory is modelled here and read combinationally
//            at pc_out; expected values are hand-computed per vector.
// Config   : SINGLE_STEP_EN - connects step and runs the single-step vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int PC_W = 8;
  localparam int IW   = 15;
`ifdef SINGLE_STEP_EN
  localparam int CPI = 4;  // FETCH, DECODE, EXEC, WAIT (step held high)
`else
  localparam int CPI = 3;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [IW-1:0]   im_data;
  logic            alu_z, alu_n, alu_c;
  logic [PC_W-1:0] pc_out;
  logic            la, lb;
  logic [1:0]      sa, sb;
  logic [2:0]      alu_op;
  logic [7:0]      literal;
  logic            halted;
  logic [15:0]     retired;
`ifdef SINGLE_STEP_EN
  logic            step;
`endif

  logic [IW-1:0] mem [0:255];
  assign im_data = mem[pc_out];

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .IW(IW)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef SINGLE_STEP_EN
    .step    (step),
`endif
    .im_data (im_data),
    .alu_z   (alu_z),
    .alu_n   (alu_n),
    .alu_c   (alu_c),
    .pc_out  (pc_out),
    .la      (la),
    .lb      (lb),
    .sa      (sa),
    .sb      (sb),
    .alu_op  (alu_op),
    .literal (literal),
    .halted  (halted),
    .retired (retired)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [6:0] op,
                                        input logic [7:0] lit);
    return {op, lit};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // CMP latches {z,n,c}, then the branch at address 1 executes.
  task automatic run_branch(input string tag, input logic z, input logic n,
                            input logic c, input logic [6:0] op,
                            input logic [7:0] lit, input logic [7:0] exp_pc);
    clear_mem();
    mem[0] = ins(7'h14, 8'h00);  // CMP
    mem[1] = ins(op, lit);
    alu_z = z; alu_n = n; alu_c = c;
    do_reset();
    tick(2 * CPI);
    check(tag, pc_out, exp_pc);
  endtask

  initial begin
    int la_cnt;
    int bad;
    rst = 1'b1;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    clear_mem();

    // Reset and first-instruction latency
    mem[0] = ins(7'h01, 8'h11);  // MOV A,#0x11
    do_reset();
    check("rst_pc", pc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_ctl", {la, lb, sa, sb, alu_op}, 0);
    tick(1);
    check("decode_la", la, 0);
    tick(1);
    check("exec3_la", la, 1);
    check("exec3_sa", sa, 2);
    check("exec3_lit", literal, 8'h11);

    // Straight-line MOVs
    clear_mem();
    mem[0] = ins(7'h01, 8'h11);
    mem[1] = ins(7'h01, 8'h22);
    mem[2] = ins(7'h01, 8'h33);
    do_reset();
    la_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("line_pc%0d", i), pc_out, i);
      for (int k = 0; k < CPI; k++) begin
        la_cnt += int'(la);
        tick(1);
      end
    end
    check("line_la_pulses", la_cnt, 3);
    check("line_retired", retired, 3);
    check("line_pc3", pc_out, 3);

    // Branches
    run_branch("jeq_taken",    1, 0, 0, 7'h41, 8'h05, 8'h05);
    run_branch("jeq_fallthru", 0, 0, 0, 7'h41, 8'h05, 8'h02);
    run_branch("jne_taken",    0, 0, 0, 7'h42, 8'h20, 8'h20);
    run_branch("jne_fallthru", 1, 0, 0, 7'h42, 8'h20, 8'h02);
    run_branch("jmp",          0, 0, 0, 7'h40, 8'h30, 8'h30);
    run_branch("jlt_taken",    0, 1, 0, 7'h43, 8'h07, 8'h07);
    run_branch("jcr_fallthru", 0, 0, 0, 7'h44, 8'h09, 8'h02);
    run_branch("jcr_taken",    0, 0, 1, 7'h44, 8'h09, 8'h09);

    // Branch sees the flags latched by CMP, not the live ALU status
    clear_mem();
    mem[0] = ins(7'h14, 8'h00);
    mem[1] = ins(7'h41, 8'h05);
    alu_z = 1'b1;
    do_reset();
    tick(CPI);
    alu_z = 1'b0;
    tick(CPI);
    check("jeq_latched_flag", pc_out, 8'h05);

    // Undefined opcode behaves as NOP
    clear_mem();
    mem[0] = ins(7'h55, 8'hAB);
    do_reset();
    tick(2);
    check("undef_ctl", {la, lb, sa, sb, alu_op}, 0);
    tick(CPI - 2);
    check("undef_pc", pc_out, 1);
    check("undef_retired", retired, 1);

    // PC wrap
    clear_mem();
    mem[0]   = ins(7'h40, 8'hFF);  // JMP 0xFF
    mem[255] = ins(7'h00, 8'h00);  // NOP
    do_reset();
    tick(CPI);
    check("wrap_pc_ff", pc_out, 8'hFF);
    tick(CPI);
    check("wrap_pc_00", pc_out, 8'h00);
    check("wrap_retired", retired, 2);

    // Halt
    clear_mem();
    mem[0]    = ins(7'h40, 8'h0A);  // JMP 0x0A
    mem[8'h0A] = ins(7'h7F, 8'h00); // HALT
    do_reset();
    tick(CPI + 2);
    check("halt_exec_halted", halted, 0);
    tick(1);
    check("halt_halted", halted, 1);
    check("halt_pc", pc_out, 8'h0A);
    check("halt_retired", retired, 2);
    bad = 0;
    repeat (20) begin
      if (pc_out != 8'h0A || la || lb || sa != 0 || sb != 0 || alu_op != 0 || !halted)
        bad++;
      tick(1);
    end
    check("halt_hold20", bad, 0);
    check("halt_retired_hold", retired, 2);
    do_reset();
    check("halt_rst_pc", pc_out, 0);
    check("halt_rst_halted", halted, 0);
    check("halt_rst_retired", retired, 0);

    // Reset in the middle of an EXEC clears flags and counter
    clear_mem();
    mem[0] = ins(7'h14, 8'h00);  // CMP with Z=1
    mem[1] = ins(7'h41, 8'h05);  // JEQ 0x05
    alu_z = 1'b1;
    do_reset();
    tick(CPI + 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midexec_pc", pc_out, 0);
    check("midexec_retired", retired, 0);
    mem[0] = ins(7'h41, 8'h05);  // JEQ with Z cleared by reset
    alu_z = 1'b0;
    tick(CPI);
    check("midexec_flags_cleared", pc_out, 1);

`ifdef SINGLE_STEP_EN
    // Single-step
    clear_mem();
    mem[0] = ins(7'h01, 8'h01);
    mem[1] = ins(7'h01, 8'h02);
    mem[2] = ins(7'h01, 8'h03);
    step = 1'b0;
    do_reset();
    tick(3);
    check("step_first_retired", retired, 1);
    tick(10);
    check("step_wait_retired", retired, 1);
    check("step_wait_pc", pc_out, 1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    check("step_one_retired", retired, 2);
    tick(5);
    check("step_hold_retired", retired, 2);
    step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL take parameter PC_W, default 8, as the program-counter width.
REQ-002 The block SHALL take parameter IW, default 15, as the instruction width, split as opcode [IW-1:8] (7 bits) and literal [7:0].
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 im_data  input  IW  instruction read combinationally from instruction memory at pc_out.
REQ-006 alu_z, alu_n, alu_c  input  1 each  ALU zero, negative and carry status for the current EXEC operands.
REQ-007 pc_out  output  PC_W  instruction-memory address.
REQ-008 la, lb  output  1 each  regA and regB load enables.
REQ-009 sa, sb  output  2 each  ALU A-mux and B-mux selects.
REQ-010 alu_op  output  3  ALU operation select.
REQ-011 literal  output  8  literal field of the latched instruction.
REQ-012 halted  output  1  high while the sequencer is in HALT.
REQ-013 retired  output  16  count of executed instructions.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC and HALT; each instruction SHALL take exactly 3 cycles: FETCH->DECODE->EXEC->FETCH.
REQ-015 In FETCH, pc_out SHALL present the PC; at the end of FETCH, im_data SHALL latch into the instruction register (ir).
REQ-016 In DECODE, decoder outputs SHALL be computed from ir; la, lb and flag_we SHALL stay 0.
REQ-017 la, lb, sa, sb and alu_op SHALL be driven from the decode word only in EXEC; la and lb SHALL be 0 in every other state.
REQ-018 In EXEC with flag_we=1, {Z,N,C} SHALL latch from alu_z/alu_n/alu_c.
REQ-019 Branches SHALL use the flags latched before the current EXEC: JMP 0x40 always; JEQ 0x41 if Z=1; JNE 0x42 if Z=0; JLT 0x43 if N=1; JCR 0x44 if C=1.
REQ-020 A taken branch SHALL load PC := literal at the end of EXEC; otherwise PC := PC+1 modulo 2^PC_W, so 0xFF wraps to 0x00.
REQ-021 Opcode 0x7F SHALL move the FSM from EXEC to HALT; the PC SHALL not change and halted SHALL be 1 from the next cycle.
REQ-022 HALT SHALL be left only by rst; in HALT all enables SHALL be 0.
REQ-023 An undefined opcode SHALL execute as NOP 0x00: all enables 0, PC+1, and the instruction counts as retired.
REQ-024 retired SHALL increment by 1 at the end of every EXEC, including HALT and NOP, and SHALL saturate at 0xFFFF.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to FETCH, with PC=0, ir=0, flags=0, retired=0 and halted=0; la=lb=0, sa=sb=0 and alu_op=0.
REQ-026 rst SHALL override any state, including mid-EXEC, HALT and a simultaneous step; no partial instruction effect SHALL survive it.

Configuration
REQ-027 With macro SINGLE_STEP_EN defined, the block SHALL add input step (1 bit) and a state WAIT between EXEC and FETCH.
REQ-028 With SINGLE_STEP_EN, the FSM SHALL leave WAIT for FETCH only on a cycle with step=1; step SHALL be ignored in other states.
REQ-029 Without SINGLE_STEP_EN, the step port and the WAIT state SHALL not exist, and EXEC SHALL go directly to FETCH.

Structure
REQ-030 Package seq_pkg SHALL hold the opcode constants, the FSM state enum, the decode-word struct {la, lb, sa, sb, alu_op, flag_we, is_branch, is_halt} and the ALU-select constants.
REQ-031 A combinational sub-module instr_decoder SHALL map a 7-bit opcode to the decode word; the FSM, PC, flags and counter SHALL stay in instr_sequencer.

Verification
REQ-032 Reset test: rst=1 for 2 cycles, then 0 -> pc_out=0x00, halted=0, retired=0, la=lb=0, and the first EXEC occurs in the 3rd cycle after release.
REQ-033 Straight-line test: three MOV instructions at 0x00-0x02 -> pc_out steps 0,1,2 every 3 cycles, la pulses exactly 1 cycle per instruction, and retired=3.
REQ-034 Branch test: CMP with alu_z=1, then JEQ 0x05 -> pc_out=0x05; the same with alu_z=0 -> pc_out = branch address + 1.
REQ-035 Wrap test: NOP at PC 0xFF -> next pc_out=0x00.
REQ-036 Halt test: 0x7F at PC 0x0A -> halted=1, pc_out stays 0x0A for 20 cycles with enables 0; rst then restarts at 0x00.
REQ-037 Step test (SINGLE_STEP_EN): no step for 10 cycles -> the FSM stays in WAIT and retired is unchanged; a 1-cycle step pulse -> exactly one instruction retires.
